// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//
// Streams 32-bit instruction words from a valid/ready source into the write
// port of the pc-indexed instruction RAM. Words land at consecutive
// addresses, starting at a base address captured together with the word count
// on a one-cycle start request. Each write is issued exactly one cycle after
// its word is accepted.
//
// Optional build macro: LOADER_CHECKSUM_EN
//   When defined, the checksum_o port is added. It carries the modulo-2^DATA_WIDTH
//   sum of every word accepted since the last accepted start.
//
// Ports:
//   clk_i        system clock, rising-edge
//   reset_i      synchronous active-high reset
//   start_i      one-cycle load request (honoured only in IDLE)
//   base_addr_i  first instruction address of the load
//   length_i     number of words to load
//   in_valid_i   in_data_i holds a word
//   in_data_i    instruction word
//   in_ready_o   loader accepts a word this cycle
//   mem_we_o     instruction RAM write enable
//   mem_addr_o   instruction RAM write address (held when mem_we_o=0)
//   mem_data_o   instruction RAM write data (held when mem_we_o=0)
//   busy_o       high while loading or flushing the final write
//   done_o       one-cycle completion pulse
//   checksum_o   (LOADER_CHECKSUM_EN only) sum of accepted words
//   err_o        sticky range error; cleared by the next accepted start
//
// States:
//   state   | meaning
//   IDLE    | waiting for start
//   LOAD    | accepting words, each written one cycle later
//   FLUSH   | final write on the RAM port, no more words accepted
//   DONE    | completion pulse, back to IDLE next cycle
// -----------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  busy_o,
  output logic                  done_o,
`ifdef LOADER_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum_o,
`endif
  output logic                  err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // The range check needs one bit beyond the wider of address and length.
  localparam int SumW = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;
  localparam logic [SumW-1:0] AddrSpace = SumW'(1) << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q,  base_d;
  logic [LEN_WIDTH-1:0]  len_q,   len_d;
  logic [LEN_WIDTH-1:0]  idx_q,   idx_d;
  logic                  err_q,   err_d;
  logic                  we_q,    we_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q,  csum_d;
`endif

  logic [SumW-1:0] end_addr;
  logic            range_ovf;
  logic            last_word;

  assign end_addr  = SumW'(base_addr_i) + SumW'(length_i);
  assign range_ovf = end_addr > AddrSpace;
  assign last_word = (idx_q == (len_q - LEN_WIDTH'(1)));

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    err_d      = err_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    in_ready_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          base_d = base_addr_i;
          len_d  = length_i;
          idx_d  = '0;
          err_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          csum_d = '0;
`endif
          // An empty load is never a range error, so it is checked first.
          if (length_i == '0) begin
            state_d = S_DONE;
          end else if (range_ovf) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (in_valid_i) begin
          we_d   = 1'b1;
          addr_d = base_q + ADDR_WIDTH'(idx_q);
          data_d = in_data_i;
          idx_d  = idx_q + LEN_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q + in_data_i;
`endif
          if (last_word) begin
            state_d = S_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        busy_o  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign mem_we_o   = we_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign err_o      = err_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum_o = csum_q;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          busy;
  logic          done;
  logic          err;
`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  always #5 clk = ~clk;

  instr_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .base_addr_i(base_addr),
    .length_i   (length),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_data),
    .busy_o     (busy),
    .done_o     (done),
`ifdef LOADER_CHECKSUM_EN
    .checksum_o (checksum),
`endif
    .err_o      (err)
  );

  int checks   = 0;
  int failures = 0;

  // Last write seen on the RAM port; address/data must hold these when idle.
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;

  typedef struct {
    logic [AW-1:0] base;
    int            len;
    int            gap;
    bit            exp_err;
    int            exp_nw;
    logic [DW-1:0] exp_csum;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] dut_csum();
`ifdef LOADER_CHECKSUM_EN
    return checksum;
`else
    return '0;
`endif
  endfunction

  task automatic chk_quiet(input string tag, input bit exp_err);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_we"},    mem_we,   0);
    chk({tag, "_busy"},  busy,     0);
    chk({tag, "_done"},  done,     0);
    chk({tag, "_err"},   err,      exp_err);
  endtask

  // One complete load request. Expected per-cycle behaviour is derived from
  // the word count and the bench's own valid pattern: word k goes to base+k
  // one cycle after it is offered; in_ready is high from the cycle after start
  // until the last word is taken; done follows the flush cycle.
  task automatic run_load(input logic [AW-1:0] b, input int len, input int gap,
                          input bit rnd, output int nw, output bit err_seen,
                          output logic [DW-1:0] cs);
    longint unsigned end_addr;
    bit              zero;
    bit              ovf;
    int              k;
    int              s;
    bit              v;
    logic [DW-1:0]   word;
    logic [DW-1:0]   sum;
    logic [AW-1:0]   exp_a;

    end_addr = longint'(b) + longint'(len);
    zero     = (len == 0);
    ovf      = !zero && (end_addr > (64'd1 << AW));
    k        = 0;
    sum      = '0;
    nw       = 0;

    start     = 1'b1;
    base_addr = b;
    length    = LW'(len);
    in_valid  = 1'($urandom_range(0, 1));
    in_data   = $urandom;
    tick();
    start = 1'b0;

    if (zero || ovf) begin
      chk("imm_done",  done,     1);
      chk("imm_busy",  busy,     0);
      chk("imm_ready", in_ready, 0);
      chk("imm_we",    mem_we,   0);
      chk("imm_err",   err,      ovf);
      chk("imm_csum",  dut_csum(), 0);
      err_seen = err;
      cs       = dut_csum();
      in_valid = 1'b1;
      tick();
      chk_quiet("imm_after", ovf);
      chk("imm_addr_hold", mem_addr, last_addr);
      chk("imm_data_hold", mem_data, last_data);
      in_valid = 1'b0;
      return;
    end

    chk("ld_ready0", in_ready, 1);
    chk("ld_busy0",  busy,     1);
    chk("ld_done0",  done,     0);
    chk("ld_we0",    mem_we,   0);
    chk("ld_err0",   err,      0);

    s = 1;
    while (k < len) begin
      if (rnd) v = (s > 60) ? 1'b1 : ($urandom_range(0, 2) != 0);
      else     v = (s == 1) || (s > gap + 1);
      word      = rnd ? DW'($urandom) : (DW'(32'hA) + DW'(k));
      in_valid  = v;
      in_data   = v ? word : DW'($urandom);
      start     = ($urandom_range(0, 3) == 0);
      base_addr = AW'($urandom);
      length    = LW'($urandom);
      tick();
      start = 1'b0;
      if (mem_we) nw++;
      if (v) begin
        exp_a = b + AW'(k);
        chk("wr_we",   mem_we,   1);
        chk("wr_addr", mem_addr, exp_a);
        chk("wr_data", mem_data, word);
        last_addr = exp_a;
        last_data = word;
        sum       = sum + word;
        k++;
      end else begin
        chk("gap_we",   mem_we,   0);
        chk("gap_addr", mem_addr, last_addr);
        chk("gap_data", mem_data, last_data);
      end
      chk("ld_ready", in_ready, (k < len));
      chk("ld_busy",  busy,     1);
      chk("ld_done",  done,     0);
      s++;
    end

    // FLUSH cycle is on the bus now; next edge enters DONE.
    in_valid  = 1'b1;
    in_data   = $urandom;
    start     = 1'b1;
    base_addr = AW'($urandom);
    tick();
    if (mem_we) nw++;
    chk("dn_done",  done,     1);
    chk("dn_busy",  busy,     0);
    chk("dn_ready", in_ready, 0);
    chk("dn_we",    mem_we,   0);
    chk("dn_addr",  mem_addr, last_addr);
    chk("dn_err",   err,      0);
`ifdef LOADER_CHECKSUM_EN
    chk("dn_csum",  checksum, sum);
`endif
    err_seen = err;
    cs       = dut_csum();

    // Start during DONE is ignored as well.
    start    = ($urandom_range(0, 1) != 0);
    in_valid = 1'b1;
    tick();
    start = 1'b0;
    if (mem_we) nw++;
    chk_quiet("post", 0);
    chk("post_data", mem_data, last_data);
`ifdef LOADER_CHECKSUM_EN
    chk("post_csum", checksum, sum);
`endif
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int            nw;
    bit            e;
    logic [DW-1:0] cs;
    logic [AW-1:0] rb;
    int            rl;
    bit            rovf;

    tbl[0] = '{base: 26'h40,      len: 3, gap: 0, exp_err: 0, exp_nw: 3, exp_csum: 32'h21};
    tbl[1] = '{base: 26'h40,      len: 3, gap: 2, exp_err: 0, exp_nw: 3, exp_csum: 32'h21};
    tbl[2] = '{base: 26'h0,       len: 0, gap: 0, exp_err: 0, exp_nw: 0, exp_csum: 32'h0};
    tbl[3] = '{base: 26'h3FFFFFE, len: 3, gap: 0, exp_err: 1, exp_nw: 0, exp_csum: 32'h0};
    tbl[4] = '{base: 26'h3FFFFFD, len: 3, gap: 1, exp_err: 0, exp_nw: 3, exp_csum: 32'h21};
    tbl[5] = '{base: 26'h100,     len: 1, gap: 0, exp_err: 0, exp_nw: 1, exp_csum: 32'hA};
    tbl[6] = '{base: 26'h3FFFFFF, len: 2, gap: 0, exp_err: 1, exp_nw: 0, exp_csum: 32'h0};
    tbl[7] = '{base: 26'h1234,    len: 4, gap: 3, exp_err: 0, exp_nw: 4, exp_csum: 32'h2E};

    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    last_addr = '0;
    last_data = '0;

    tick();
    tick();
    reset = 1'b0;
    chk_quiet("rst", 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    in_valid = 1'b1;
    tick();
    chk_quiet("idle_valid", 0);
    in_valid = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_load(tbl[i].base, tbl[i].len, tbl[i].gap, 1'b0, nw, e, cs);
      chk($sformatf("tbl%0d_nw", i), nw, tbl[i].exp_nw);
      chk($sformatf("tbl%0d_err", i), e, tbl[i].exp_err);
`ifdef LOADER_CHECKSUM_EN
      chk($sformatf("tbl%0d_csum", i), cs, tbl[i].exp_csum);
`endif
    end

    // Reset in the middle of a 4-word load after two words.
    start = 1'b1; base_addr = 26'h200; length = 16'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h11;
    tick();
    chk("mid_w0_addr", mem_addr, 26'h200);
    in_data = 32'h22;
    tick();
    chk("mid_w1_addr", mem_addr, 26'h201);
    chk("mid_w1_data", mem_data, 32'h22);
    in_data = 32'h33;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    chk_quiet("mid_rst", 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_data", mem_data, 0);
`ifdef LOADER_CHECKSUM_EN
    chk("mid_rst_csum", checksum, 0);
`endif
    last_addr = '0;
    last_data = '0;
    in_data = 32'h44;
    tick();
    chk_quiet("mid_after", 0);
    in_valid = 1'b0;
    run_load(26'h300, 2, 0, 1'b0, nw, e, cs);
    chk("mid_reload_nw", nw, 2);
`ifdef LOADER_CHECKSUM_EN
    chk("mid_reload_csum", cs, 32'h15);
`endif

    // Randomized loads, including ranges that end at or past the top.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) rb = AW'((64'd1 << AW) - 64'($urandom_range(1, 20)));
      else                           rb = AW'($urandom);
      rl   = $urandom_range(0, 12);
      rovf = (rl != 0) && ((longint'(rb) + longint'(rl)) > (64'd1 << AW));
      run_load(rb, rl, 0, 1'b1, nw, e, cs);
      chk($sformatf("rnd%0d_nw", i), nw, rovf ? 0 : rl);
      chk($sformatf("rnd%0d_err", i), e, rovf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
